// File: rtl/reg_file_2r1w_if.sv
`default_nettype none
// =============================================================================
// Module   : reg_file_2r1w_if
// Desc     : Clear, write and dual read bundle for reg_file_2r1w.
// Revision : 1.0 - initial release
// =============================================================================
interface reg_file_2r1w_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) ();
  logic                  clr_req;
  logic                  busy;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W/8-1:0]   wr_be;
  logic [DATA_W-1:0]     wr_data;
  logic                  wr_drop;
  logic                  rd_en_a;
  logic [ADDR_W-1:0]     rd_addr_a;
  logic [DATA_W-1:0]     rd_data_a;
  logic                  rd_valid_a;
  logic                  rd_en_b;
  logic [ADDR_W-1:0]     rd_addr_b;
  logic [DATA_W-1:0]     rd_data_b;
  logic                  rd_valid_b;

  modport master (
    output clr_req, wr_en, wr_addr, wr_be, wr_data,
    output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    input  busy, wr_drop, rd_data_a, rd_valid_a, rd_data_b, rd_valid_b
  );

  modport slave (
    input  clr_req, wr_en, wr_addr, wr_be, wr_data,
    input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    output busy, wr_drop, rd_data_a, rd_valid_a, rd_data_b, rd_valid_b
  );
endinterface
`default_nettype wire

// File: rtl/reg_file_2r1w.sv
`default_nettype none
// =============================================================================
// Module   : reg_file_2r1w
// Desc     : 2 registered read ports, 1 byte-enabled write port, clear sweep.
//            Define REGFILE_BYPASS_EN for write-first collisions (else read-first).
// Revision : 1.0 - initial release
// =============================================================================
module reg_file_2r1w #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  reg_file_2r1w_if.slave   bus
);

  localparam int                c_BE_W     = DATA_W / 8;
  localparam logic [ADDR_W:0]   c_NUM_REGS = NUM_REGS[ADDR_W:0];
  localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_ptr;
  logic [ADDR_W-1:0]   w_clr_ptr_nxt;
  logic                w_clr_we;
  logic                w_wr_accept;
  logic                w_wr_in_range;
  logic                w_drop_nxt;
  logic                r_wr_drop;

  // No reset on the array so it maps onto distributed RAM.
  logic [DATA_W-1:0]   r_mem [NUM_REGS];

  assign w_wr_in_range = ({1'b0, bus.wr_addr} < c_NUM_REGS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    w_clr_we      = 1'b0;
    w_wr_accept   = 1'b0;
    w_drop_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.clr_req) begin
          // Clear wins over a same-cycle write.
          w_state_nxt   = S_CLEAR;
          w_clr_ptr_nxt = '0;
          w_drop_nxt    = bus.wr_en;
        end else begin
          w_wr_accept = bus.wr_en && w_wr_in_range;
          w_drop_nxt  = bus.wr_en && !w_wr_in_range;
        end
      end
      S_CLEAR: begin
        w_clr_we      = 1'b1;
        w_drop_nxt    = bus.wr_en;
        w_clr_ptr_nxt = r_clr_ptr + ADDR_W'(1);
        if (r_clr_ptr == c_LAST_IDX) begin
          w_state_nxt   = S_IDLE;
          w_clr_ptr_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = S_CLEAR;
        w_clr_ptr_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= w_drop_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_wr_accept) begin
      for (int i = 0; i < c_BE_W; i++) begin
        if (bus.wr_be[i]) begin
          r_mem[bus.wr_addr][i*8 +: 8] <= bus.wr_data[i*8 +: 8];
        end
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic [DATA_W-1:0] w_wr_old;
  logic [DATA_W-1:0] w_wr_merged;

  assign w_wr_old = r_mem[bus.wr_addr];

  always_comb begin
    w_wr_merged = w_wr_old;
    for (int i = 0; i < c_BE_W; i++) begin
      if (bus.wr_be[i]) begin
        w_wr_merged[i*8 +: 8] = bus.wr_data[i*8 +: 8];
      end
    end
  end
`endif

  logic [1:0]          w_rd_en;
  logic [2*ADDR_W-1:0] w_rd_addr;
  logic [1:0]          w_rd_valid;
  logic [2*DATA_W-1:0] w_rd_data;

  assign w_rd_en   = {bus.rd_en_b, bus.rd_en_a};
  assign w_rd_addr = {bus.rd_addr_b, bus.rd_addr_a};

  generate
    for (genvar p = 0; p < 2; p++) begin : g_rd_port
      logic [ADDR_W-1:0] w_addr;
      logic              w_in_range;
      logic [DATA_W-1:0] w_word;
      logic              r_valid;
      logic [DATA_W-1:0] r_data;

      assign w_addr     = w_rd_addr[p*ADDR_W +: ADDR_W];
      assign w_in_range = ({1'b0, w_addr} < c_NUM_REGS);
`ifdef REGFILE_BYPASS_EN
      assign w_word = (w_wr_accept && (w_addr == bus.wr_addr)) ? w_wr_merged : r_mem[w_addr];
`else
      assign w_word = r_mem[w_addr];
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
          r_data  <= '0;
        end else if (r_state == S_CLEAR) begin
          r_valid <= 1'b0;
          r_data  <= '0;
        end else if (w_rd_en[p]) begin
          r_valid <= 1'b1;
          r_data  <= w_in_range ? w_word : '0;
        end else begin
          r_valid <= 1'b0;
        end
      end

      assign w_rd_valid[p]                 = r_valid;
      assign w_rd_data[p*DATA_W +: DATA_W] = r_data;
    end
  endgenerate

  assign bus.busy       = (r_state == S_CLEAR);
  assign bus.wr_drop    = r_wr_drop;
  assign bus.rd_valid_a = w_rd_valid[0];
  assign bus.rd_data_a  = w_rd_data[0 +: DATA_W];
  assign bus.rd_valid_b = w_rd_valid[1];
  assign bus.rd_data_b  = w_rd_data[DATA_W +: DATA_W];

endmodule
`default_nettype wire

// File: tb/tb_reg_file_2r1w.sv
`default_nettype none
// =============================================================================
// Module   : tb_reg_file_2r1w
// Desc     : Self-checking bench for reg_file_2r1w (16-entry and 12-entry builds).
// Revision : 1.0 - initial release
// =============================================================================
module tb_reg_file_2r1w;
  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int N   = 16;
  localparam int N12 = 12;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reg_file_2r1w_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  reg_file_2r1w_if #(.DATA_W(DW), .ADDR_W(AW)) bus12 ();

  reg_file_2r1w #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(N)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  reg_file_2r1w #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(N12)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .bus(bus12)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state for the 16-entry instance.
  logic [DW-1:0] m_mem [N];
  bit            m_busy;
  int            m_ptr;
  bit            e_busy, e_drop, e_va, e_vb;
  logic [DW-1:0] e_da, e_db;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [DW/8-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < DW/8; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 1'b1; m_ptr = 0;
    e_busy = 1'b1; e_drop = 1'b0; e_va = 1'b0; e_vb = 1'b0; e_da = '0; e_db = '0;
  endtask

  task automatic model_edge();
    bit            acc;
    logic [DW-1:0] nv;
    if (m_busy) begin
      e_va = 1'b0; e_vb = 1'b0; e_da = '0; e_db = '0;
      e_drop = bus.wr_en;
      m_mem[m_ptr] = '0;
      m_ptr++;
      if (m_ptr == N) m_busy = 1'b0;
    end else begin
      acc = bus.wr_en && !bus.clr_req && (int'(bus.wr_addr) < N);
      nv  = merge(m_mem[bus.wr_addr], bus.wr_data, bus.wr_be);
      if (bus.rd_en_a) begin
        e_va = 1'b1;
        e_da = (BYP && acc && bus.rd_addr_a == bus.wr_addr) ? nv : m_mem[bus.rd_addr_a];
      end else e_va = 1'b0;
      if (bus.rd_en_b) begin
        e_vb = 1'b1;
        e_db = (BYP && acc && bus.rd_addr_b == bus.wr_addr) ? nv : m_mem[bus.rd_addr_b];
      end else e_vb = 1'b0;
      e_drop = bus.wr_en && !acc;
      if (acc) m_mem[bus.wr_addr] = nv;
      if (bus.clr_req) begin m_busy = 1'b1; m_ptr = 0; end
    end
    e_busy = m_busy;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_main();
    bus.clr_req = 0; bus.wr_en = 0; bus.wr_addr = '0; bus.wr_be = '0; bus.wr_data = '0;
    bus.rd_en_a = 0; bus.rd_addr_a = '0; bus.rd_en_b = 0; bus.rd_addr_b = '0;
  endtask

  task automatic idle_small();
    bus12.clr_req = 0; bus12.wr_en = 0; bus12.wr_addr = '0; bus12.wr_be = '0; bus12.wr_data = '0;
    bus12.rd_en_a = 0; bus12.rd_addr_a = '0; bus12.rd_en_b = 0; bus12.rd_addr_b = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] be);
    bus.wr_en = 1; bus.wr_addr = a; bus.wr_data = d; bus.wr_be = be;
    cyc();
    bus.wr_en = 0;
  endtask

  task automatic test_reset();
    int n = 0;
    int n12 = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.busy, bus.wr_drop, bus.rd_valid_a, bus.rd_data_a, bus.rd_valid_b, bus.rd_data_b, bus12.busy}
        !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_values: got busy=%b drop=%b va=%b a=%h vb=%b b=%h busy12=%b expected 1 0 0 0 0 0 1",
               bus.busy, bus.wr_drop, bus.rd_valid_a, bus.rd_data_a, bus.rd_valid_b, bus.rd_data_b, bus12.busy);
    end
    #2 rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cyc();
      n++;
      if (!bus12.busy && n12 == 0) n12 = n;
      if (!bus.busy) break;
    end
    n_checks++;
    if (n !== 16) begin n_fail++; $display("FAIL reset_busy_len: got %0d expected 16", n); end
    n_checks++;
    if (n12 !== 12) begin n_fail++; $display("FAIL reset_busy_len12: got %0d expected 12", n12); end
    for (int i = 0; i < N; i++) begin
      bus.rd_en_a = 1; bus.rd_addr_a = AW'(i); bus.rd_en_b = 1; bus.rd_addr_b = AW'(N-1-i);
      cyc();
      n_checks++;
      if ({bus.rd_valid_a, bus.rd_data_a, bus.rd_valid_b, bus.rd_data_b} !== {1'b1, 32'h0, 1'b1, 32'h0}) begin
        n_fail++;
        $display("FAIL reset_read_zero[%0d]: got va=%b a=%h vb=%b b=%h expected 1 0 1 0", i,
                 bus.rd_valid_a, bus.rd_data_a, bus.rd_valid_b, bus.rd_data_b);
      end
    end
    idle_main();
  endtask

  task automatic test_small_regs();
    bus12.wr_en = 1; bus12.wr_addr = 4'd11; bus12.wr_data = 32'hCAFEF00D; bus12.wr_be = 4'hF;
    cyc();
    n_checks++;
    if (bus12.wr_drop !== 1'b0) begin n_fail++; $display("FAIL small_last_ok_drop: got %b expected 0", bus12.wr_drop); end
    bus12.wr_addr = 4'd15; bus12.wr_data = 32'hDEADBEEF;
    cyc();
    n_checks++;
    if (bus12.wr_drop !== 1'b1) begin n_fail++; $display("FAIL small_drop15: got %b expected 1", bus12.wr_drop); end
    bus12.wr_addr = 4'd12;
    cyc();
    n_checks++;
    if (bus12.wr_drop !== 1'b1) begin n_fail++; $display("FAIL small_drop12: got %b expected 1", bus12.wr_drop); end
    bus12.wr_en = 0;
    bus12.rd_en_a = 1; bus12.rd_addr_a = 4'd11; bus12.rd_en_b = 1; bus12.rd_addr_b = 4'd15;
    cyc();
    n_checks++;
    if ({bus12.wr_drop, bus12.rd_valid_a, bus12.rd_data_a, bus12.rd_valid_b, bus12.rd_data_b}
        !== {1'b0, 1'b1, 32'hCAFEF00D, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL small_read: got drop=%b va=%b a=%h vb=%b b=%h expected 0 1 cafef00d 1 0",
               bus12.wr_drop, bus12.rd_valid_a, bus12.rd_data_a, bus12.rd_valid_b, bus12.rd_data_b);
    end
    bus12.rd_en_a = 0; bus12.rd_addr_b = 4'd3;
    cyc();
    n_checks++;
    if ({bus12.rd_valid_a, bus12.rd_data_a, bus12.rd_valid_b, bus12.rd_data_b}
        !== {1'b0, 32'hCAFEF00D, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL small_hold_noalias: got va=%b a=%h vb=%b b=%h expected 0 cafef00d 1 0",
               bus12.rd_valid_a, bus12.rd_data_a, bus12.rd_valid_b, bus12.rd_data_b);
    end
    idle_small();
  endtask

  task automatic test_byte_mask();
    wr(4'd5, 32'hAABBCCDD, 4'b1111);
    wr(4'd5, 32'h11223344, 4'b0101);
    wr(4'd5, 32'hFFFFFFFF, 4'b0000);
    bus.rd_en_a = 1; bus.rd_addr_a = 4'd5;
    cyc();
    n_checks++;
    if ({bus.rd_valid_a, bus.rd_data_a, bus.wr_drop} !== {1'b1, 32'hAA22CC44, 1'b0}) begin
      n_fail++;
      $display("FAIL byte_mask: got va=%b a=%h drop=%b expected 1 aa22cc44 0", bus.rd_valid_a, bus.rd_data_a, bus.wr_drop);
    end
    idle_main();
  endtask

  task automatic test_dual_read();
    wr(4'd3, 32'h1, 4'hF);
    wr(4'd9, 32'h2, 4'hF);
    bus.rd_en_a = 1; bus.rd_addr_a = 4'd3; bus.rd_en_b = 1; bus.rd_addr_b = 4'd9;
    cyc();
    n_checks++;
    if ({bus.rd_valid_a, bus.rd_data_a, bus.rd_valid_b, bus.rd_data_b} !== {1'b1, 32'h1, 1'b1, 32'h2}) begin
      n_fail++;
      $display("FAIL dual_read: got va=%b a=%h vb=%b b=%h expected 1 1 1 2",
               bus.rd_valid_a, bus.rd_data_a, bus.rd_valid_b, bus.rd_data_b);
    end
    bus.rd_addr_a = 4'd9;
    cyc();
    n_checks++;
    if ({bus.rd_data_a, bus.rd_data_b} !== {32'h2, 32'h2}) begin
      n_fail++; $display("FAIL same_addr: got a=%h b=%h expected 2 2", bus.rd_data_a, bus.rd_data_b);
    end
    bus.rd_en_a = 0; bus.rd_en_b = 0;
    cyc();
    n_checks++;
    if ({bus.rd_valid_a, bus.rd_data_a, bus.rd_valid_b, bus.rd_data_b} !== {1'b0, 32'h2, 1'b0, 32'h2}) begin
      n_fail++;
      $display("FAIL read_hold: got va=%b a=%h vb=%b b=%h expected 0 2 0 2",
               bus.rd_valid_a, bus.rd_data_a, bus.rd_valid_b, bus.rd_data_b);
    end
    idle_main();
  endtask

  task automatic test_collision();
    logic [DW-1:0] exp_first;
    exp_first = BYP ? 32'h9 : 32'h5;
    wr(4'd7, 32'h5, 4'hF);
    bus.wr_en = 1; bus.wr_addr = 4'd7; bus.wr_data = 32'h9; bus.wr_be = 4'hF;
    bus.rd_en_a = 1; bus.rd_addr_a = 4'd7;
    cyc();
    n_checks++;
    if (bus.rd_data_a !== exp_first) begin
      n_fail++; $display("FAIL collision_first: got %h expected %h", bus.rd_data_a, exp_first);
    end
    bus.wr_en = 0;
    cyc();
    n_checks++;
    if (bus.rd_data_a !== 32'h9) begin
      n_fail++; $display("FAIL collision_next: got %h expected 9", bus.rd_data_a);
    end
    idle_main();
  endtask

  task automatic test_clear_mid_use();
    int k;
    for (int i = 0; i < N; i++) wr(AW'(i), $urandom | 32'h1, 4'hF);
    bus.rd_en_a = 1; bus.rd_addr_a = 4'd0; bus.rd_en_b = 1; bus.rd_addr_b = 4'd15;
    cyc();
    n_checks++;
    if ({bus.rd_data_a, bus.rd_data_b} !== {e_da, e_db} || e_da == 32'h0) begin
      n_fail++; $display("FAIL fill_read: got a=%h b=%h expected %h %h", bus.rd_data_a, bus.rd_data_b, e_da, e_db);
    end
    idle_main();
    bus.clr_req = 1; bus.wr_en = 1; bus.wr_addr = 4'd2; bus.wr_data = 32'h1234; bus.wr_be = 4'hF;
    cyc();
    k = 0;
    n_checks++;
    if ({bus.busy, bus.wr_drop} !== 2'b11) begin
      n_fail++; $display("FAIL clr_accept: got busy=%b drop=%b expected 1 1", bus.busy, bus.wr_drop);
    end
    idle_main();
    bus.rd_en_a = 1; bus.rd_addr_a = 4'd4;
    cyc(); k++;
    n_checks++;
    if ({bus.rd_valid_a, bus.rd_data_a} !== {1'b0, 32'h0}) begin
      n_fail++; $display("FAIL busy_read: got va=%b a=%h expected 0 0", bus.rd_valid_a, bus.rd_data_a);
    end
    bus.rd_en_a = 0;
    cyc(); k++;
    cyc(); k++;
    bus.wr_en = 1; bus.wr_addr = 4'd6; bus.clr_req = 1;
    cyc(); k++;
    n_checks++;
    if ({bus.busy, bus.wr_drop} !== 2'b11) begin
      n_fail++; $display("FAIL clr_wr_drop: got busy=%b drop=%b expected 1 1", bus.busy, bus.wr_drop);
    end
    idle_main();
    cyc(); k++;
    n_checks++;
    if (bus.wr_drop !== 1'b0) begin n_fail++; $display("FAIL clr_drop_pulse: got %b expected 0", bus.wr_drop); end
    while (bus.busy && k < 40) begin cyc(); k++; end
    n_checks++;
    if (k !== 16) begin n_fail++; $display("FAIL clr_busy_len: got %0d expected 16", k); end
    for (int i = 0; i < N; i++) begin
      bus.rd_en_a = 1; bus.rd_addr_a = AW'(i); bus.rd_en_b = 1; bus.rd_addr_b = AW'(N-1-i);
      cyc();
      n_checks++;
      if ({bus.rd_valid_a, bus.rd_data_a, bus.rd_valid_b, bus.rd_data_b} !== {1'b1, 32'h0, 1'b1, 32'h0}) begin
        n_fail++;
        $display("FAIL clr_read_zero[%0d]: got va=%b a=%h vb=%b b=%h expected 1 0 1 0", i,
                 bus.rd_valid_a, bus.rd_data_a, bus.rd_valid_b, bus.rd_data_b);
      end
    end
    idle_main();
  endtask

  task automatic test_async_reset();
    int k = 0;
    for (int i = 0; i < N; i++) wr(AW'(i), $urandom | 32'h100, 4'hF);
    bus.clr_req = 1;
    cyc();
    bus.clr_req = 0;
    repeat (4) cyc();
    bus.wr_en = 1; bus.wr_addr = 4'd3;
    cyc();
    bus.wr_en = 0;
    n_checks++;
    if (bus.wr_drop !== 1'b1) begin n_fail++; $display("FAIL pre_reset_drop: got %b expected 1", bus.wr_drop); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({bus.busy, bus.wr_drop, bus.rd_valid_a, bus.rd_data_a, bus.rd_valid_b, bus.rd_data_b}
        !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL async_reset_values: got busy=%b drop=%b va=%b a=%h vb=%b b=%h expected 1 0 0 0 0 0",
               bus.busy, bus.wr_drop, bus.rd_valid_a, bus.rd_data_a, bus.rd_valid_b, bus.rd_data_b);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    while (k < 40) begin
      cyc(); k++;
      if (!bus.busy) break;
    end
    n_checks++;
    if (k !== 16) begin n_fail++; $display("FAIL async_busy_len: got %0d expected 16", k); end
    for (int i = 0; i < N; i++) begin
      bus.rd_en_a = 1; bus.rd_addr_a = AW'(i); bus.rd_en_b = 1; bus.rd_addr_b = AW'(N-1-i);
      cyc();
      n_checks++;
      if ({bus.rd_valid_a, bus.rd_data_a, bus.rd_valid_b, bus.rd_data_b} !== {1'b1, 32'h0, 1'b1, 32'h0}) begin
        n_fail++;
        $display("FAIL async_read_zero[%0d]: got va=%b a=%h vb=%b b=%h expected 1 0 1 0", i,
                 bus.rd_valid_a, bus.rd_data_a, bus.rd_valid_b, bus.rd_data_b);
      end
    end
    idle_main();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.clr_req   = ($urandom_range(0, 63) == 0);
      bus.wr_en     = 1'($urandom_range(0, 1));
      bus.wr_addr   = AW'($urandom_range(0, N-1));
      bus.wr_be     = 4'($urandom);
      bus.wr_data   = $urandom;
      bus.rd_en_a   = ($urandom_range(0, 3) != 0);
      bus.rd_addr_a = $urandom_range(0, 1) ? bus.wr_addr : AW'($urandom_range(0, N-1));
      bus.rd_en_b   = ($urandom_range(0, 3) != 0);
      bus.rd_addr_b = $urandom_range(0, 1) ? bus.wr_addr : AW'($urandom_range(0, N-1));
      cyc();
      n_checks++;
      if ({bus.busy, bus.wr_drop} !== {e_busy, e_drop}) begin
        n_fail++;
        $display("FAIL rand_ctrl[%0d]: got busy=%b drop=%b expected %b %b", c, bus.busy, bus.wr_drop, e_busy, e_drop);
      end
      n_checks++;
      if ({bus.rd_valid_a, bus.rd_data_a} !== {e_va, e_da}) begin
        n_fail++;
        $display("FAIL rand_port_a[%0d]: got va=%b a=%h expected %b %h", c, bus.rd_valid_a, bus.rd_data_a, e_va, e_da);
      end
      n_checks++;
      if ({bus.rd_valid_b, bus.rd_data_b} !== {e_vb, e_db}) begin
        n_fail++;
        $display("FAIL rand_port_b[%0d]: got vb=%b b=%h expected %b %h", c, bus.rd_valid_b, bus.rd_data_b, e_vb, e_db);
      end
    end
    idle_main();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_main();
    idle_small();
    for (int i = 0; i < N; i++) m_mem[i] = '0;
    model_reset();
    test_reset();
    test_small_regs();
    test_byte_mask();
    test_dual_read();
    test_collision();
    test_clear_mid_use();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Parametrised successor to the team's single-port register file: 2 registered read ports, 1 write port with byte enables, and a hardware clear sequencer.
- Sits between decode/execute as the general-purpose register bank. Also used as a small scratch RAM by peripheral controllers.
- The array is zeroed by a counter-driven sweep, not by reset fan-out, so it stays mappable to distributed RAM.

Parameters:
- DATA_W, 32, data width in bits. Must be a multiple of 8.
- ADDR_W, 4, address width.
- NUM_REGS, 16, number of entries. Must satisfy NUM_REGS <= 2**ADDR_W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr_req  in  1  one-cycle pulse; requests a full-array clear.
- busy  out  1  high while the clear sweep runs.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_be  in  DATA_W/8  byte enables.
- wr_data  in  DATA_W  write data.
- wr_drop  out  1  one-cycle pulse when a write is discarded.
- rd_en_a  in  1  port A read request.
- rd_addr_a  in  ADDR_W  port A address.
- rd_data_a  out  DATA_W  port A data.
- rd_valid_a  out  1  port A data valid.
- rd_en_b, rd_addr_b, rd_data_b, rd_valid_b: port B, identical to port A.

Behaviour:
- Reset (rst_n=0, async):
  - busy=1, wr_drop=0, rd_data_a/b=0, rd_valid_a/b=0.
  - FSM=CLEAR, clr_ptr=0.
  - Array contents are not reset directly.
- FSM states:
  - IDLE: busy=0. clr_req=1 -> CLEAR with clr_ptr=0.
  - CLEAR: busy=1. Each cycle writes 0 to rf[clr_ptr] and increments clr_ptr. At clr_ptr==NUM_REGS-1, that entry is written and the FSM goes to IDLE next cycle.
  - CLEAR lasts exactly NUM_REGS cycles. After rst_n rises, busy falls after NUM_REGS rising edges.
  - clr_req while in CLEAR is ignored; the sweep does not restart.
- Write (IDLE only):
  - wr_en=1 and wr_addr<NUM_REGS: bytes with wr_be[i]=1 are updated at the edge; other bytes are unchanged.
  - wr_be=0 is a legal no-op.
- wr_drop pulses high for 1 cycle, on the edge after the offending request, when any of these holds:
  - wr_en=1 during CLEAR;
  - wr_en=1 with wr_addr>=NUM_REGS;
  - wr_en=1 in the same cycle IDLE accepts clr_req (clear has priority).
- Read, per port, independently:
  - 1-cycle latency. rd_en=1 at edge N gives rd_data/rd_valid=1 at edge N+1.
  - rd_en=0: rd_valid=0 next cycle and rd_data holds its last value.
  - Reads during busy: rd_valid=0, rd_data=0.
  - Address >= NUM_REGS: rd_valid=1, rd_data=0.
- Collisions:
  - Both ports reading the same address is legal; both get identical data.
  - Read and write to the same address in the same cycle: see Optional Feature.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read colliding with an accepted write returns the post-write value (merged per wr_be) one cycle later (write-first).
- Undefined: the read returns the pre-write value (read-first). The new value is visible to reads issued from the next cycle.
- Clear writes are never bypassed in either configuration, because reads are invalid while busy.

Test Plan:
- Reset sweep: rst_n low 3 cycles, then high -> busy=1 for exactly 16 cycles. Then read all 16 addresses on A and B -> every read returns 0 with rd_valid=1.
- Byte-masked write: write 0xAABBCCDD to addr 5 with be=4'b1111, then 0x11223344 with be=4'b0101 -> read of addr 5 returns 0xAA22CC44.
- Dual read + drops:
  - Write addr 3=0x1, addr 9=0x2. Read A@3 and B@9 in the same cycle -> next cycle A=0x1, B=0x2, both valid.
  - Write to addr 15 with NUM_REGS=12 -> wr_drop pulses and the write has no effect.
- Collision: addr 7 holds 0x5. Write 0x9 to addr 7 and read A@7 in the same cycle -> 0x9 with REGFILE_BYPASS_EN, 0x5 without. Following read returns 0x9 in both.
- Clear mid-use: fill all entries nonzero, pulse clr_req, assert wr_en on cycle 4 of the sweep -> wr_drop pulses, busy lasts 16 cycles, then all reads return 0.
- Async reset mid-sweep: assert rst_n=0 at cycle 6 of a clear -> outputs take reset values immediately and the sweep restarts at clr_ptr=0 after release.
